// File: rtl/sub8_serial.sv
// ---------------------------------------------------------------------------
// sub8_serial
// Multi-cycle unsigned subtractor: wx = x_a - x_b mod 2^WIDTH, evaluated as
// x_a + ~x_b + 1 one 8-bit chunk per clock, LSB chunk first. The carry between
// chunks is held in a register, so a single 8-bit adder slice serves the
// whole operand width.
//
// Optional feature (compile-time macro SUB8_SERIAL_BORROW_EN):
//   adds output `borrow`, the inverted final carry (1 when x_a < x_b),
//   valid with out_valid and held with wx.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   x_a        in   WIDTH  minuend, sampled on input handshake
//   x_b        in   WIDTH  subtrahend, sampled on input handshake
//   out_valid  out  1      wx holds a completed result
//   out_ready  in   1      consumer accepts the result
//   wx         out  WIDTH  difference, registered
//   borrow     out  1      (SUB8_SERIAL_BORROW_EN only) x_a < x_b
// ---------------------------------------------------------------------------
module sub8_serial #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_a,
    input  logic [WIDTH-1:0] x_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] wx
`ifdef SUB8_SERIAL_BORROW_EN
    ,
    output logic             borrow
`endif
);

    localparam int unsigned     NCHUNK   = WIDTH / 8;
    localparam int unsigned     CNT_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    if ((WIDTH < 8) || ((WIDTH % 8) != 0)) begin : g_bad_width
        $error("sub8_serial: WIDTH must be a multiple of 8 and >= 8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               load_c;
    logic               step_c;
    logic               out_valid_nxt;
    logic               in_ready_nxt;
    logic [7:0]         a_chunk_c;
    logic [7:0]         b_chunk_c;
    logic [7:0]         b_inv_c;
    logic [8:0]         sum_c;

    // Select the operand chunk addressed by the chunk counter
    always_comb begin
        a_chunk_c = '0;
        b_chunk_c = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_chunk_c = a_q[i*8 +: 8];
                b_chunk_c = b_q[i*8 +: 8];
            end
        end
    end

    // Shared 8-bit adder slice: a + ~b + carry
    always_comb begin
        b_inv_c = ~b_chunk_c;
        sum_c   = {1'b0, a_chunk_c} + {1'b0, b_inv_c} + {8'd0, carry_q};
    end

    // Next-state and registered-output decode
    always_comb begin
        state_nxt     = state;
        load_c        = 1'b0;
        step_c        = 1'b0;
        out_valid_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    load_c    = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                step_c = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // out_valid rises one clock after entering DONE and holds until taken
                out_valid_nxt = 1'b1;
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        in_ready_nxt = (state_nxt == S_IDLE);
    end

    // State and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Operand capture, chunk counter, carry chain and result chunks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            wx      <= '0;
        end else begin
            if (load_c) begin
                a_q     <= x_a;
                b_q     <= x_b;
                carry_q <= 1'b1;
                cnt_q   <= '0;
            end
            if (step_c) begin
                for (int unsigned i = 0; i < NCHUNK; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        wx[i*8 +: 8] <= sum_c[7:0];
                    end
                end
                carry_q <= sum_c[8];
                cnt_q   <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef SUB8_SERIAL_BORROW_EN
    // Capture the inverted final carry as out_valid is about to rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow <= 1'b0;
        end else if ((state == S_DONE) && !out_valid) begin
            borrow <= ~carry_q;
        end
    end
`endif

endmodule
